psum_drain: RTL and testbench
=============================

// Module: psum_drain
// PURPOSE
// Output stage directly below the weight-stationary MAC array; consumes the bottom-row acc_out of every column.
// Deskews column outputs, accumulates partial sums across K-tiles in a row buffer, requantizes (round, shift, saturate).
// Queues finished rows in an output FIFO for the writeback engine under valid/ready.
// PARAMETERS
// COLS        16  array columns = lanes per row
// ACC_WIDTH   32  per-lane partial-sum width (equals array acc_width_next)
// BIT_WIDTH    8  requantized output width per lane
// DEPTH       64  accumulation buffer rows (max output rows per tile)
// FIFO_DEPTH  32  output FIFO entries; must be >= COLS+2
// PORTS
// clk        in   1                  clock
// rst        in   1                  synchronous reset, active-high
// in_valid   in   1                  column-0 beat valid; lane c data arrives c cycles later
// acc_in     in   COLS*ACC_WIDTH     bottom-row acc_out, lane c at [c*ACC_WIDTH +: ACC_WIDTH], signed
// first_tile in   1                  tag with column-0 beat: overwrite buffer row
// last_tile  in   1                  tag with column-0 beat: emit row after accumulate
// rows_cfg   in   $clog2(DEPTH)+1    rows per tile, 1..DEPTH; held static while busy
// shift_amt  in   5                  requant arithmetic right shift, 0..ACC_WIDTH-1
// in_ready   out  1                  upstream may issue a new column-0 beat
// out_valid  out  1                  FIFO head valid
// out_ready  in   1                  consumer accepts head
// out_data   out  COLS*BIT_WIDTH     requantized row, lane c at [c*BIT_WIDTH +: BIT_WIDTH]
// busy       out  1                  deskew beat in flight, or FIFO non-empty
// ovf        out  1                  sticky: any lane signed-overflowed in accumulate; cleared only by rst
// BEHAVIOUR
// - Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, ovf=0; row_idx=0, FIFO empty, deskew valids 0. Buffer not cleared.
// - Deskew: lane c delayed COLS-1-c registers; in_valid/first/last delayed COLS-1. Aligned beat at t+COLS-1 for in_valid at t.
// - Accumulate (aligned beat): first_tile -> buf[row_idx]=acc_in lanes; else buf[row_idx]+=lanes, two's-complement wrap at ACC_WIDTH.
// - Signed overflow on any lane in a non-first add sets ovf.
// - row_idx increments per aligned beat; wraps to 0 after rows_cfg-1. Upstream issues rows in order 0..rows_cfg-1 per tile.
// - last_tile beat: requantize the post-accumulate sum (not the stale buffer value). Push to FIFO in cycle t+COLS; buffer write still occurs.
// - first_tile&last_tile together: single-tile pass-through; result = requant(acc_in).
// - Requant per lane: if shift_amt>0, add 1<<(shift_amt-1) (round half-up) in ACC_WIDTH+1 bits.
// - Then arithmetic >> shift_amt; saturate to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
// - FIFO: first-word fall-through from a registered array. Pushed entry visible as out_valid at t+COLS+1 (latency COLS+1).
// - Pop when out_valid&out_ready. Push+pop same cycle: occupancy unchanged. Pop while empty: ignored.
// - in_ready (registered) = occupancy + in-flight last_tile beats <= FIFO_DEPTH-COLS-1. Guarantees no push into full FIFO.
// - in_valid while in_ready=0 is a protocol error; the bench asserts it never happens.
// - rst mid-operation: in-flight beats dropped, FIFO emptied, row_idx=0, ovf=0. Next tile must start with first_tile.
// STRUCTURE
// - Shared header rpaccel_defs.vh: ACC_WIDTH, BIT_WIDTH, COLS defaults and the lane-slice macro.
// - One sub-module: psum_out_fifo (sync FIFO, WIDTH/DEPTH params, push/pop/count/full/empty).
// - Deskew, buffer, requant stay inline; requant is a function, not a module.
// TESTING (COLS=4, ACC_WIDTH=32, BIT_WIDTH=8, DEPTH=8, FIFO_DEPTH=8)
// 1 rows_cfg=2, single tile (first&last), lanes {10,-3,127,200}, shift 0 -> out_valid at t+5; out {10,-3,127,127}.
// 2 Two tiles, rows_cfg=1: tile0 lanes all 100, tile1 lanes all 60, shift 4 -> 160+8>>4=10 each lane; one FIFO entry only.
// 3 Rounding/saturation, single tile, shift 2: lanes {5,6,-6,-1000} -> {1,2,-1,-128}.
// 4 out_ready=0, stream last_tile beats: in_ready drops at occupancy+inflight>3; no entries lost.
//   Release out_ready: 8 entries drain in order.
// 5 Overflow: tile0 lanes 0x7FFFFFF0, tile1 lanes 0x20 -> ovf=1, held until rst; wrapped sum stored.
// 6 rst asserted 2 cycles after in_valid -> no out_valid ever; ovf=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/psum_drain_pkg.sv
// Shared defaults and helpers for the partial-sum drain stage below the MAC array.
package psum_drain_pkg;

    localparam int unsigned PD_COLS       = 16;
    localparam int unsigned PD_ACC_WIDTH  = 32;
    localparam int unsigned PD_BIT_WIDTH  = 8;
    localparam int unsigned PD_DEPTH      = 64;
    localparam int unsigned PD_FIFO_DEPTH = 32;

    // Two's-complement add overflow from the operand and result sign bits.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Synchronous first-word fall-through FIFO holding finished requantized rows.
module psum_out_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
            if (do_pop)  rd_q <= (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/psum_drain.sv
// Drain stage: deskews bottom-row column outputs, accumulates K-tiles per row,
// requantizes finished rows and queues them for writeback.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int unsigned COLS       = PD_COLS,
    parameter int unsigned ACC_WIDTH  = PD_ACC_WIDTH,
    parameter int unsigned BIT_WIDTH  = PD_BIT_WIDTH,
    parameter int unsigned DEPTH      = PD_DEPTH,
    parameter int unsigned FIFO_DEPTH = PD_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [COLS*ACC_WIDTH-1:0] acc_in,
    input  logic                      first_tile,
    input  logic                      last_tile,
    input  logic [$clog2(DEPTH):0]    rows_cfg,
    input  logic [4:0]                shift_amt,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*BIT_WIDTH-1:0] out_data,
    output logic                      busy,
    output logic                      ovf
);

    localparam int unsigned RW      = $clog2(DEPTH);
    localparam int unsigned LW      = COLS*ACC_WIDTH;
    localparam int unsigned OW      = COLS*BIT_WIDTH;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH+1);
    localparam int unsigned TW      = $clog2(FIFO_DEPTH+COLS+2)+1;
    localparam int unsigned ND      = COLS-1;
    localparam int unsigned RDY_MAX = FIFO_DEPTH-COLS-1;

    logic [ND-1:0]    vld_q, fst_q, lst_q;
    logic             vld_al, fst_al, lst_al;
    logic [LW-1:0]    aligned;
    logic [RW-1:0]    row_idx_q, row_idx_d;
    logic             ovf_q, push_q, in_ready_q, in_ready_d;
    logic [OW-1:0]    push_data_q;
    logic [LW-1:0]    buf_q [DEPTH];
    logic [LW-1:0]    sum_d;
    logic [OW-1:0]    req_d;
    logic             ovf_hit;
    logic [ACC_WIDTH-1:0] la, lb, ls;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty, fifo_full, pop;
    logic [OW-1:0]    fifo_head;
    logic [TW-1:0]    total_d;

    function automatic logic [BIT_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] x,
                                                     input logic [4:0] sh);
        logic signed [ACC_WIDTH:0] ext, rnd, shr, maxv, minv;
        ext  = {x[ACC_WIDTH-1], x};
        rnd  = '0;
        if (sh != 5'd0) rnd = {{ACC_WIDTH{1'b0}}, 1'b1} << (sh - 5'd1);
        shr  = (ext + rnd) >>> sh;
        maxv = {{(ACC_WIDTH-BIT_WIDTH+2){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
        minv = {{(ACC_WIDTH-BIT_WIDTH+2){1'b1}}, {(BIT_WIDTH-1){1'b0}}};
        if (shr > maxv) shr = maxv;
        if (shr < minv) shr = minv;
        return shr[BIT_WIDTH-1:0];
    endfunction

    // Lane c arrives c cycles after column 0, so it is delayed COLS-1-c stages.
    for (genvar c = 0; c < COLS; c++) begin : g_lane
        localparam int unsigned D = COLS-1-c;
        if (D == 0) begin : g_direct
            assign aligned[c*ACC_WIDTH +: ACC_WIDTH] = acc_in[c*ACC_WIDTH +: ACC_WIDTH];
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] sr_q [D];
            always_ff @(posedge clk) begin
                sr_q[0] <= acc_in[c*ACC_WIDTH +: ACC_WIDTH];
                for (int unsigned i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
            end
            assign aligned[c*ACC_WIDTH +: ACC_WIDTH] = sr_q[D-1];
        end
    end

    assign vld_al = vld_q[ND-1];
    assign fst_al = fst_q[ND-1];
    assign lst_al = lst_q[ND-1];

    always_comb begin
        sum_d   = '0;
        req_d   = '0;
        ovf_hit = 1'b0;
        la      = '0;
        lb      = '0;
        ls      = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            la = aligned[c*ACC_WIDTH +: ACC_WIDTH];
            lb = buf_q[row_idx_q][c*ACC_WIDTH +: ACC_WIDTH];
            ls = la + lb;
            if (fst_al) begin
                sum_d[c*ACC_WIDTH +: ACC_WIDTH] = la;
            end else begin
                sum_d[c*ACC_WIDTH +: ACC_WIDTH] = ls;
                if (add_ovf(la[ACC_WIDTH-1], lb[ACC_WIDTH-1], ls[ACC_WIDTH-1])) ovf_hit = 1'b1;
            end
            req_d[c*BIT_WIDTH +: BIT_WIDTH] = requant(sum_d[c*ACC_WIDTH +: ACC_WIDTH], shift_amt);
        end
    end

    always_comb begin
        row_idx_d = row_idx_q;
        if (vld_al) begin
            row_idx_d = ({1'b0, row_idx_q} == rows_cfg - 1'b1) ? '0 : row_idx_q + 1'b1;
        end
    end

    // Next-cycle occupancy plus every last_tile beat still travelling toward the FIFO.
    always_comb begin
        total_d = TW'(fifo_count) + TW'(push_q) - TW'(pop) + TW'(in_valid & last_tile);
        for (int unsigned i = 0; i < ND; i++) total_d = total_d + TW'(vld_q[i] & lst_q[i]);
        in_ready_d = (total_d <= TW'(RDY_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            fst_q       <= '0;
            lst_q       <= '0;
            row_idx_q   <= '0;
            ovf_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            vld_q[0] <= in_valid;
            fst_q[0] <= first_tile;
            lst_q[0] <= last_tile;
            for (int unsigned i = 1; i < ND; i++) begin
                vld_q[i] <= vld_q[i-1];
                fst_q[i] <= fst_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
            row_idx_q   <= row_idx_d;
            ovf_q       <= ovf_q | (vld_al & ovf_hit);
            push_q      <= vld_al & lst_al;
            push_data_q <= req_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && vld_al) buf_q[row_idx_q] <= sum_d;
    end

    psum_out_fifo #(
        .WIDTH (OW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_q & ~fifo_full),
        .data_i  (push_data_q),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign out_data  = fifo_empty ? '0 : fifo_head;
    assign busy      = (|vld_q) | push_q | ~fifo_empty;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: vector table, directed multi-cycle sequences and a
// randomized run checked against a queue/array reference model.
module tb_psum_drain;

    localparam int COLS  = 4;
    localparam int AW    = 32;
    localparam int BW    = 8;
    localparam int DEPTH = 8;
    localparam int FD    = 8;

    typedef logic [COLS-1:0][AW-1:0] lanes_t;
    typedef logic [COLS*BW-1:0]      row_t;

    typedef struct {
        lanes_t d;
        int     sh;
        int     rows;
        row_t   exp;
    } vec_t;

    logic                 clk, rst, in_valid, first_tile, last_tile;
    logic [COLS*AW-1:0]   acc_in;
    logic [$clog2(DEPTH):0] rows_cfg;
    logic [4:0]           shift_amt;
    logic                 in_ready, out_valid, out_ready, busy, ovf;
    row_t                 out_data;

    int     total, bad, pops;
    lanes_t hist [COLS];
    row_t   expq [$];
    longint mbuf [DEPTH][COLS];
    int     mrow;
    bit     movf;
    vec_t   vt [5];

    psum_drain #(
        .COLS       (COLS),
        .ACC_WIDTH  (AW),
        .BIT_WIDTH  (BW),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .acc_in     (acc_in),
        .first_tile (first_tile),
        .last_tile  (last_tile),
        .rows_cfg   (rows_cfg),
        .shift_amt  (shift_amt),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int rq(input longint x, input int sh);
        longint y;
        y = x + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0);
        y = y >>> sh;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return int'(y);
    endfunction

    task automatic model_beat(input logic f, input logic l, input lanes_t d);
        row_t row;
        row = '0;
        for (int c = 0; c < COLS; c++) begin
            longint a, s;
            int q;
            a = longint'($signed(d[c]));
            if (f) begin
                mbuf[mrow][c] = a;
            end else begin
                s = mbuf[mrow][c] + a;
                if (s > 64'sd2147483647 || s < -64'sd2147483648) movf = 1'b1;
                mbuf[mrow][c] = longint'($signed(s[31:0]));
            end
            q = rq(mbuf[mrow][c], int'(shift_amt));
            row[c*BW +: BW] = q[BW-1:0];
        end
        if (l) expq.push_back(row);
        mrow = (mrow + 1) % int'(rows_cfg);
    endtask

    // Called at a negedge: drives one cycle of stimulus, checks any pop, advances a cycle.
    task automatic step(input logic v, input logic f, input logic l, input lanes_t d);
        for (int k = COLS-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = v ? d : '0;
        for (int c = 0; c < COLS; c++) acc_in[c*AW +: AW] = hist[c][c];
        in_valid   = v;
        first_tile = f;
        last_tile  = l;
        if (v) begin
            chk("proto_in_ready", in_ready, 1);
            model_beat(f, l, d);
        end
        if (out_valid && out_ready) begin
            pops++;
            if (expq.size() == 0) chk("spurious_out", 1, 0);
            else chk("row_data", out_data, expq.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        first_tile = 1'b0;
        last_tile  = 1'b0;
        acc_in     = '0;
        for (int k = 0; k < COLS; k++) hist[k] = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        mrow = 0;
        movf = 1'b0;
        pops = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((expq.size() != 0 || busy) && n < 200) begin
            idle();
            n++;
        end
        chk("drain_timeout", n < 200, 1);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            idle();
            n++;
        end
        chk("out_timeout", out_valid, 1);
    endtask

    function automatic lanes_t splat(input logic [AW-1:0] x);
        lanes_t d;
        for (int c = 0; c < COLS; c++) d[c] = x;
        return d;
    endfunction

    initial begin
        total = 0; bad = 0; pops = 0;
        rows_cfg  = 2;
        shift_amt = '0;
        out_ready = 1'b1;

        vt[0] = '{d: {32'd200, 32'd127, -32'sd3, 32'd10},          sh: 0,  rows: 2, exp: 32'h7F7FFD0A};
        vt[1] = '{d: {-32'sd1000, -32'sd6, 32'd6, 32'd5},          sh: 2,  rows: 2, exp: 32'h80FF0201};
        vt[2] = '{d: {32'd0, -32'sd129, -32'sd128, -32'sd200},     sh: 0,  rows: 2, exp: 32'h00808080};
        vt[3] = '{d: {-32'sd257, -32'sd255, 32'd256, 32'd255},     sh: 1,  rows: 2, exp: 32'h80817F7F};
        vt[4] = '{d: {-32'sd1000, 32'd1000, 32'h80000000, 32'h7FFFFFFF}, sh: 31, rows: 2, exp: 32'h0000FF01};

        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);

        // Single-tile pass-through vectors with exact output latency.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            rows_cfg  = vt[i].rows[$clog2(DEPTH):0];
            shift_amt = vt[i].sh[4:0];
            step(1'b1, 1'b1, 1'b1, vt[i].d);
            chk("vec_busy", busy, 1);
            for (int k = 0; k < 4; k++) begin
                chk("vec_early_valid", out_valid, 0);
                idle();
            end
            chk("vec_latency", out_valid, 1);
            chk("vec_data", out_data, vt[i].exp);
            drain();
        end

        // Two K-tiles into one row; only the last tile emits.
        do_reset();
        rows_cfg  = 1;
        shift_amt = 5'd4;
        step(1'b1, 1'b1, 1'b0, splat(32'd100));
        step(1'b1, 1'b0, 1'b1, splat(32'd60));
        wait_out();
        chk("t2_data", out_data, 32'h0A0A0A0A);
        drain();
        chk("t2_pops", pops, 1);

        // Backpressure: throttle, hold, then release and drain in order.
        begin
            int issued, first_stall;
            do_reset();
            rows_cfg    = 1;
            shift_amt   = '0;
            out_ready   = 1'b0;
            issued      = 0;
            first_stall = -1;
            for (int cy = 0; cy < 300 && issued < 8; cy++) begin
                if (cy == 19) begin
                    chk("t4_hold_ready", in_ready, 0);
                    chk("t4_hold_valid", out_valid, 1);
                end
                if (cy == 20) out_ready = 1'b1;
                if (in_ready) begin
                    lanes_t d;
                    for (int c = 0; c < COLS; c++) d[c] = 32'(issued*16 + c);
                    step(1'b1, 1'b1, 1'b1, d);
                    issued++;
                end else begin
                    if (first_stall < 0) first_stall = issued;
                    idle();
                end
            end
            chk("t4_issued", issued, 8);
            chk("t4_stall_at", first_stall, 4);
            drain();
            chk("t4_pops", pops, 8);
        end

        // Overflow, wrapped storage, sticky flag.
        do_reset();
        rows_cfg  = 1;
        shift_amt = '0;
        step(1'b1, 1'b1, 1'b0, splat(32'h7FFFFFF0));
        step(1'b1, 1'b0, 1'b1, splat(32'h00000020));
        step(1'b1, 1'b0, 1'b1, splat(32'h7FFFFFF0));
        drain();
        chk("t5_pops", pops, 2);
        chk("t5_ovf", ovf, 1);
        chk("t5_model_ovf", ovf, movf);
        for (int k = 0; k < 5; k++) idle();
        chk("t5_ovf_sticky", ovf, 1);

        // Reset with a beat in flight.
        shift_amt = '0;
        step(1'b1, 1'b1, 1'b1, splat(32'd5));
        idle();
        do_reset();
        chk("t6_in_ready", in_ready, 1);
        chk("t6_ovf", ovf, 0);
        chk("t6_busy", busy, 0);
        for (int k = 0; k < 12; k++) begin
            chk("t6_no_valid", out_valid, 0);
            idle();
        end

        // Randomized tiles against the reference model.
        do_reset();
        for (int run = 0; run < 8; run++) begin
            int tiles;
            rows_cfg  = ($clog2(DEPTH)+1)'($urandom_range(1, DEPTH));
            shift_amt = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 10));
            tiles     = $urandom_range(1, 3);
            for (int t = 0; t < tiles; t++) begin
                for (int r = 0; r < int'(rows_cfg); r++) begin
                    lanes_t d;
                    int n;
                    for (int c = 0; c < COLS; c++)
                        d[c] = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4000)) - 32'd2000;
                    n = 0;
                    while (!in_ready && n < 100) begin
                        out_ready = ($urandom_range(0, 3) != 0);
                        idle();
                        n++;
                    end
                    chk("rand_ready_timeout", in_ready, 1);
                    out_ready = ($urandom_range(0, 3) != 0);
                    step(1'b1, t == 0, t == tiles-1, d);
                    if ($urandom_range(0, 3) == 0) idle();
                end
            end
            drain();
            chk("rand_ovf", ovf, movf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
